// File: rtl/score_bcd_converter_if.sv
// Handshake/result bundle between the game controller, the BCD converter and the display driver.
// The controller side is the master; the converter is the slave.
interface score_bcd_converter_if #(
    parameter int unsigned SCORE_W = 14
);
    logic [SCORE_W-1:0] GameScore;
    logic               Start;
    logic               Busy;
    logic               Done;
    logic [15:0]        BcdDigits;
    logic               Overflow;

    modport master (
        output GameScore,
        output Start,
        input  Busy,
        input  Done,
        input  BcdDigits,
        input  Overflow
    );

    modport slave (
        input  GameScore,
        input  Start,
        output Busy,
        output Done,
        output BcdDigits,
        output Overflow
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter: saturated binary score -> four packed BCD digits, one bit per clock.
// Optional macro SCORE_LZB_EN blanks leading zero digits (4'hF) when the result is loaded.
module score_bcd_converter #(
    parameter int unsigned SCORE_W   = 14,
    parameter int unsigned MAX_SCORE = 9999
) (
    input  logic                  Clk,
    input  logic                  Rst,
    score_bcd_converter_if.slave  bus
);
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned NIBBLES = BCD_W / 4;
    localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic               over_max;

`ifdef SCORE_LZB_EN
    // Replace leading zero digits above the ones digit with the blank code.
    function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        for (int i = NIBBLES - 1; i >= 1; i--) begin
            if (lead && (d[i*4 +: 4] == 4'h0)) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    assign over_max = (bus.GameScore > SCORE_W'(MAX_SCORE));

    // Add-3 correction on every nibble that would reach 10 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        pend_d   = pend_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        digits_d = digits_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_SHIFT;
                    bin_d   = over_max ? SCORE_W'(MAX_SCORE) : bus.GameScore;
                    pend_d  = over_max;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                bcd_d  = BCD_W'({bcd_adj, bin_q[SCORE_W-1]});
                bin_d  = {bin_q[SCORE_W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = pend_q;
`ifdef SCORE_LZB_EN
                    digits_d = blank_lz(bcd_d);
`else
                    digits_d = bcd_d;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.BcdDigits = digits_q;
    assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: directed boundary cases plus randomized traffic,
// checked against a decimal-arithmetic reference model (honours SCORE_LZB_EN).
module tb_score_bcd_converter;
    localparam int unsigned SCORE_W = 14;

    typedef struct {
        int          acc_cyc;
        int          done_cyc;
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    logic Clk;
    logic Rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    logic [15:0] held_dig;
    logic        held_ovf;

    score_bcd_converter_if #(.SCORE_W(SCORE_W)) bus ();

    score_bcd_converter #(.SCORE_W(SCORE_W), .MAX_SCORE(9999)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: saturate, split into decimal digits, optionally blank leading zeros.
    function automatic exp_t ref_model(input int unsigned score);
        exp_t        e;
        int unsigned s;
        int unsigned d[4];
        logic        lead;
        s    = (score > 9999) ? 9999 : score;
        d[0] = s / 1000;
        d[1] = (s / 100) % 10;
        d[2] = (s / 10) % 10;
        d[3] = s % 10;
        for (int i = 0; i < 4; i++) e.dig[15 - 4*i -: 4] = 4'(d[i]);
        lead = 1'b1;
`ifdef SCORE_LZB_EN
        for (int i = 0; i < 3; i++) begin
            if (lead && d[i] == 0) e.dig[15 - 4*i -: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        e.ovf      = (score > 9999);
        e.acc_cyc  = 0;
        e.done_cyc = 0;
        return e;
    endfunction

    // One clock of stimulus; a request seen while idle is recorded in the scoreboard.
    task automatic drive_cycle(input logic st, input logic [SCORE_W-1:0] sc);
        exp_t e;
        @(negedge Clk);
        #1;
        bus.Start     = st;
        bus.GameScore = sc;
        if (st && !bus.Busy && !Rst) begin
            e          = ref_model(int'(sc));
            e.acc_cyc  = cyc + 1;
            e.done_cyc = cyc + 15;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            drive_cycle(1'b0, SCORE_W'($urandom_range(0, 16383)));
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [SCORE_W-1:0] pick_score();
        case ($urandom_range(0, 6))
            0:       return SCORE_W'(0);
            1:       return SCORE_W'(9999);
            2:       return SCORE_W'(10000);
            3:       return SCORE_W'(16383);
            4:       return SCORE_W'($urandom_range(0, 99));
            default: return SCORE_W'($urandom_range(0, 16383));
        endcase
    endfunction

    // Monitor: Busy window, Done timing, and result hold are checked every cycle.
    always @(negedge Clk) begin : monitor
        logic exp_busy;
        logic exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sb.size() > 0) begin
            exp_busy = (cyc >= sb[0].acc_cyc) && (cyc < sb[0].done_cyc);
            exp_done = (cyc == sb[0].done_cyc);
        end
        check("busy", 32'(bus.Busy), 32'(exp_busy));
        check("done", 32'(bus.Done), 32'(exp_done));
        if (exp_done) begin
            held_dig = sb[0].dig;
            held_ovf = sb[0].ovf;
            void'(sb.pop_front());
        end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
            void'(sb.pop_front());
        end
        check("bcd_digits", 32'(bus.BcdDigits), 32'(held_dig));
        check("overflow", 32'(bus.Overflow), 32'(held_ovf));
    end

    initial begin
        int unsigned dir_scores[9];
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        held_dig      = 16'h0000;
        held_ovf      = 1'b0;
        bus.Start     = 1'b0;
        bus.GameScore = '0;
        Rst           = 1'b1;
        #1;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_digits", 32'(bus.BcdDigits), 32'h0000);
        check("rst_ovf", 32'(bus.Overflow), 32'd0);
        repeat (2) @(negedge Clk);
        #1 Rst = 1'b0;

        dir_scores = '{0, 1234, 9999, 12000, 16383, 42, 1005, 10000, 9};
        foreach (dir_scores[i]) begin
            drive_cycle(1'b1, SCORE_W'(dir_scores[i]));
            wait_idle();
        end

        // Start held high: back-to-back conversions every 15 cycles.
        for (int i = 0; i < 32; i++) drive_cycle(1'b1, SCORE_W'(1234));
        drive_cycle(1'b0, '0);
        wait_idle();

        // Input changes and Start pulses during SHIFT must be ignored.
        drive_cycle(1'b1, SCORE_W'(57));
        drive_cycle(1'b0, SCORE_W'(300));
        drive_cycle(1'b0, SCORE_W'(300));
        drive_cycle(1'b1, SCORE_W'(300));
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, SCORE_W'(300));
        drive_cycle(1'b1, SCORE_W'(300));
        for (int i = 0; i < 20; i++) drive_cycle(1'b0, SCORE_W'(300));
        check("sb_empty_after_57", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-conversion.
        drive_cycle(1'b1, SCORE_W'(1234));
        wait_idle();
        drive_cycle(1'b1, SCORE_W'(4321));
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, SCORE_W'(4321));
        @(negedge Clk);
        #3;
        Rst       = 1'b1;
        bus.Start = 1'b0;
        sb.delete();
        held_dig  = 16'h0000;
        held_ovf  = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.Busy), 32'd0);
        check("async_rst_digits", 32'(bus.BcdDigits), 32'h0000);
        check("async_rst_ovf", 32'(bus.Overflow), 32'd0);
        check("async_rst_done", 32'(bus.Done), 32'd0);
        drive_cycle(1'b0, '0);
        drive_cycle(1'b0, '0);
        Rst = 1'b0;
        drive_cycle(1'b1, SCORE_W'(4321));
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if (!bus.Busy && $urandom_range(0, 2) != 0)
                drive_cycle(1'b1, pick_score());
            else
                drive_cycle(1'($urandom_range(0, 1)), SCORE_W'($urandom_range(0, 16383)));
        end
        drive_cycle(1'b0, '0);
        wait_idle();
        repeat (3) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
